// File: rtl/float_add_sched.sv
// Round-robin scheduler sharing one fixed-latency fp16 adder among NREQ requesters.
// Tags ride a LAT-deep pipeline alongside the adder so results return in issue order with the owner id.
module float_add_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 6
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_adata,
  input  logic [16*NREQ-1:0]   req_bdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          op_a,
  output logic [15:0]          op_b,
  output logic                 op_vld,
  input  logic [15:0]          res_data,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [15:0]          rsp_data,
  output logic [3:0]           inflight,
  output logic                 busy
);

  logic [1:0]     ptr;
  logic [1:0]     idx;
  logic [1:0]     grant_id;
  logic           grant_any;
  logic [1:0]     op_id;
  logic [LAT-1:0] tag_vld;
  logic [1:0]     tag_id [LAT];

  // Search ptr, ptr+1, ... ; the 2-bit index wraps modulo NREQ for free.
  always_comb begin
    idx       = '0;
    grant_id  = ptr;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    if (rst) grant_any = 1'b0;
    req_ready = grant_any ? (NREQ'(1) << grant_id) : '0;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      ptr    <= '0;
      op_vld <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
    end else begin
      op_vld <= grant_any;
      if (grant_any) begin
        ptr   <= grant_id + 2'd1;
        op_a  <= req_adata[{grant_id, 4'b0000} +: 16];
        op_b  <= req_bdata[{grant_id, 4'b0000} +: 16];
        op_id <= grant_id;
      end
    end
  end

  // Clearing tag valids on reset drops results still draining out of the adder.
  always_ff @(posedge clock) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld   <= {tag_vld[LAT-2:0], op_vld};
      tag_id[0] <= op_id;
      for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_vld[LAT-1];
      if (tag_vld[LAT-1]) begin
        rsp_data <= res_data;
        rsp_id   <= tag_id[LAT-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({grant_any, rsp_valid})
        2'b10:   if (inflight != 4'hF) inflight <= inflight + 4'd1;
        2'b01:   if (inflight != 4'h0) inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != 4'd0);

endmodule

// File: tb/tb_float_add_sched.sv
// Randomized bench for float_add_sched: a predictor queues expected responses, a monitor checks them.
module tb_float_add_sched;
  localparam int LAT = 6;

  logic        clock = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_adata, req_bdata;
  logic [3:0]  req_ready;
  logic [15:0] op_a, op_b, res_data, rsp_data;
  logic        op_vld, rsp_valid, busy;
  logic [1:0]  rsp_id;
  logic [3:0]  inflight;

  float_add_sched #(.NREQ(4), .LAT(LAT)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_adata(req_adata),
    .req_bdata(req_bdata), .req_ready(req_ready), .op_a(op_a), .op_b(op_b),
    .op_vld(op_vld), .res_data(res_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .inflight(inflight), .busy(busy)
  );

  always #5 clock = ~clock;

  // Stand-in adder: any fixed function works since the scheduler only routes data.
  logic [15:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= op_a + op_b;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign res_data = pipe[LAT-1];

  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [15:0] dat;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   cyc = 0;
  int   vec = 0;
  int   errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Predictor: abstract round-robin model, operand register model and inflight count.
  int          mptr = 0;
  int          gid;
  logic [3:0]  exp_rdy;
  logic        prev_acc = 1'b0;
  logic [15:0] prev_a = '0, prev_b = '0;
  logic [15:0] ga, gb;
  exp_t        e;

  always @(negedge clock) begin
    if (rst) begin
      chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
      mptr = 0;
      prev_acc = 1'b0;
      prev_a = '0;
      prev_b = '0;
      sb.delete();
      hist.delete();
    end else begin
      chk("op_vld", {31'd0, op_vld}, {31'd0, prev_acc});
      chk("op_a", {16'd0, op_a}, {16'd0, prev_a});
      chk("op_b", {16'd0, op_b}, {16'd0, prev_b});
      while (hist.size() > 0 && hist[0] + LAT + 2 < cyc) void'(hist.pop_front());
      chk("inflight", {28'd0, inflight}, hist.size());
      chk("busy", {31'd0, busy}, {31'd0, hist.size() != 0});
      exp_rdy = '0;
      gid = 0;
      for (int k = 0; k < 4; k++) begin
        if (exp_rdy == 0 && req_valid[(mptr + k) % 4]) begin
          gid = (mptr + k) % 4;
          exp_rdy = 4'b0001 << gid;
        end
      end
      chk("grant", {28'd0, req_ready}, {28'd0, exp_rdy});
      if (exp_rdy != 0) begin
        ga = req_adata[gid*16 +: 16];
        gb = req_bdata[gid*16 +: 16];
        e.cyc = cyc + LAT + 2;
        e.id  = 2'(gid);
        e.dat = ga + gb;
        sb.push_back(e);
        hist.push_back(cyc);
        mptr = (gid + 1) % 4;
        prev_acc = 1'b1;
        prev_a = ga;
        prev_b = gb;
      end else begin
        prev_acc = 1'b0;
      end
    end
  end

  // Monitor: every response must match the oldest expectation in cycle, id and data.
  always @(negedge clock) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missing_rsp_id", {30'd0, sb[0].id}, 32'hFFFF_FFFF);
        void'(sb.pop_front());
      end
      if (rsp_valid) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          chk("rsp_id", {30'd0, rsp_id}, {30'd0, sb[0].id});
          chk("rsp_data", {16'd0, rsp_data}, {16'd0, sb[0].dat});
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = v;
      req_adata = {$urandom(), $urandom()};
      req_bdata = {$urandom(), $urandom()};
      @(posedge clock);
      #1;
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_adata = '0;
    req_bdata = '0;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    chk("reset_op_vld", {31'd0, op_vld}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("reset_inflight", {28'd0, inflight}, 32'd0);
    @(posedge clock);
    #1;
    // Single 1.0 + 2.0 operation from requester 0.
    req_valid = 4'b0001;
    req_adata = 64'h0000_0000_0000_3C00;
    req_bdata = 64'h0000_0000_0000_4000;
    @(posedge clock);
    #1 req_valid = 4'b0000;
    drive(4'b0000, 12);
    // Saturating all four requesters.
    drive(4'b1111, 20);
    drive(4'b0000, 10);
    // Force ptr to 2, then only requesters 1 and 3 ask.
    drive(4'b0010, 1);
    drive(4'b1010, 3);
    drive(4'b0000, 10);
    // Idle gaps of five cycles between accepts.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1);
      drive(4'b0000, 5);
    end
    drive(4'b0000, 10);
    // Reset three cycles after four accepts; nothing may come back.
    drive(4'b1111, 4);
    drive(4'b0000, 3);
    rst = 1'b1;
    @(posedge clock);
    #1 rst = 1'b0;
    drive(4'b0000, 10);
    drive(4'b1111, 1);
    drive(4'b0000, 10);
    for (int i = 0; i < 300; i++) drive(4'($urandom_range(0, 15)), 1);
    drive(4'b0000, 20);
    chk("drain_pending", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/float_add_sched.md
FLOAT_ADD_SCHED -- requirements
Module: float_add_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters; ID width is 2, and values other than 4 are unsupported.
REQ-002 Parameter LAT, default 6, SHALL set the float_add latency in cycles, from op_a/op_b presented to the matching res_data.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  SHALL carry one request flag per requester.
REQ-006 req_adata  input  16*NREQ  SHALL carry operand A per requester, fp16, requester i at bits [16i+15:16i].
REQ-007 req_bdata  input  16*NREQ  SHALL carry operand B per requester, same packing as req_adata.
REQ-008 req_ready  output  NREQ  SHALL be the one-hot (or zero) grant, combinational from req_valid and the round-robin pointer.
REQ-009 op_a, op_b  output  16 each  SHALL be the registered operands driven to float_add adata/bdata.
REQ-010 op_vld  output  1  SHALL mark that op_a/op_b hold an issued operation.
REQ-011 res_data  input  16  SHALL carry float_add cdata.
REQ-012 rsp_valid  output  1  SHALL be a single-cycle result strobe.
REQ-013 rsp_id  output  2  SHALL identify the requester owning rsp_data.
REQ-014 rsp_data  output  16  SHALL carry the registered sum.
REQ-015 inflight  output  4  SHALL count operations accepted but not yet returned.
REQ-016 busy  output  1  SHALL be high whenever inflight != 0.

Function
REQ-017 Arbitration SHALL be round-robin: search starts at index ptr, then ptr+1, ..., wrapping modulo NREQ; the first set req_valid bit wins.
REQ-018 At most one req_ready bit SHALL be high per cycle; none SHALL be high when req_valid == 0.
REQ-019 A request SHALL be accepted in cycle n when req_valid[i] && req_ready[i].
REQ-020 On acceptance, ptr SHALL become (i+1) mod NREQ; without acceptance, ptr SHALL hold.
REQ-021 Accept in cycle n SHALL give op_a/op_b = requester i operands and op_vld = 1 in cycle n+1.
REQ-022 In a cycle with no acceptance, op_vld SHALL be 0 in the next cycle and op_a/op_b SHALL hold their last values.
REQ-023 A tag pipeline of LAT stages ({vld, id}) SHALL shift every cycle, loaded from {op_vld, issued id}, with no stall: the adder cannot backpressure.
REQ-024 When the tag pipeline output is valid in cycle n+1+LAT, rsp_data <= res_data and rsp_id <= tag id SHALL be registered, so that rsp_valid = 1 in cycle n+2+LAT (cycle n+8 for LAT=6).
REQ-025 Throughput SHALL be one accept per cycle sustained; back-to-back responses SHALL preserve issue order.
REQ-026 inflight SHALL increment on accept, decrement on rsp_valid, and hold when both occur in the same cycle; its maximum is LAT+2 and it never wraps.
REQ-027 rsp_valid SHALL be independent of req_valid; requesters SHALL always sink responses, as there is no rsp_ready.
REQ-028 The block SHALL NOT inspect or modify operand or result bit fields; it only routes them.

Reset
REQ-029 While rst is high: req_ready = 0, ptr = 0, op_vld = 0, op_a = op_b = 0, all tag valids = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, inflight = 0, busy = 0.
REQ-030 Reset mid-operation SHALL discard all in-flight tags: no rsp_valid for operations accepted before reset, even though the adder pipeline still drains.
REQ-031 The first grant after reset deassertion SHALL go to the lowest-index valid requester, since ptr = 0.

Verification
REQ-032 Single op: req_valid=0001, A=0x3C00 (1.0), B=0x4000 (2.0) in cycle 0 -> req_ready=0001 in cycle 0; op_vld in cycle 1; rsp_valid, rsp_id=0, rsp_data=res_data in cycle 8.
REQ-033 All four requesting continuously -> grants cycle 0,1,2,3,0,... every cycle; rsp_id sequence 0,1,2,3,0 starting cycle 8; inflight saturates at 8.
REQ-034 req_valid=1010 with ptr=2 -> grant 3, then 1, then 3; requesters 0 and 2 are never granted.
REQ-035 Accept and rsp_valid in the same cycle -> inflight unchanged; busy falls the cycle after the last rsp_valid.
REQ-036 Assert rst for 1 cycle, 3 cycles after 4 accepts -> no rsp_valid in the following 10 cycles; inflight = 0; next grant goes to requester 0.
REQ-037 Idle gap of 5 cycles between accepts -> op_vld pattern 1,0,0,0,0,0,1; rsp_valid pulses exactly 6 cycles apart.
